// File: rtl/div_root_unit_param.sv
// -----------------------------------------------------------------------------
// div_root_unit_param
//
// Parametrised fixed-point divide / n-th root engine.
//   Divide : out = floor(x * 2^FRAC_W / d)   (restoring, one quotient bit/cycle)
//   Root   : out = largest Y with Y^n <= x << (n*FRAC_W)   (bitwise trial search)
// The result is unsigned IN_W.FRAC_W fixed point. A zero second operand
// produces an error pulse with an all-ones result.
//
// Optional build macro: DIVROOT_ROUND_EN
//   When defined, one guard bit is computed below the LSB. The result is then
//   rounded half up and saturated at all ones. This costs one extra divide step,
//   or n+1 extra cycles for a root.
//
// Ports:
//   clk        in   rising-edge clock
//   rst        in   synchronous active-high reset
//   in_valid   in   operand valid, taken only while in_ready=1
//   in_ready   out  engine can accept an operand (IDLE or DONE)
//   in_mode    in   0 = divide, 1 = n-th root
//   in_data_1  in   IN_W-bit unsigned operand x
//   in_data_2  in   N_W-bit divisor d or root index n
//   out_valid  out  one-cycle result pulse
//   out_data   out  IN_W.FRAC_W result, 0 when out_valid=0
//   out_err    out  pulses with out_valid when the second operand was 0
// -----------------------------------------------------------------------------
module div_root_unit_param #(
  parameter int IN_W   = 10,
  parameter int N_W    = 3,
  parameter int FRAC_W = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_mode,
  input  logic [IN_W-1:0]          in_data_1,
  input  logic [N_W-1:0]           in_data_2,
  output logic                     out_valid,
  output logic [IN_W+FRAC_W-1:0]   out_data,
  output logic                     out_err
);

  localparam int OUT_W = IN_W + FRAC_W;
`ifdef DIVROOT_ROUND_EN
  localparam int G_W = 1;
`else
  localparam int G_W = 0;
`endif
  // Internal result width and fraction count, including the optional guard bit.
  localparam int Q_W   = OUT_W + G_W;
  localparam int F_EFF = FRAC_W + G_W;
  localparam int N_MAX = (2 ** N_W) - 1;
  // Wide enough for Yt^n_max, so the power chain never truncates.
  localparam int P_W   = N_MAX * Q_W;
  localparam int BIT_W = $clog2(Q_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DIV_STEP,
    S_ROOT_TRY,
    S_ROOT_MUL,
    S_ROOT_CMP,
    S_ERR,
    S_DONE
  } state_t;

  state_t             r_state;
  state_t             w_next;
  logic               w_in_ready;
  logic               w_accept;

  logic [N_W-1:0]     r_n;          // divisor or root index
  logic               r_err;
  logic [Q_W-1:0]     r_dvd;        // dividend, shifted out MSB first
  logic [N_W-1:0]     r_rem;        // restoring remainder, always < d
  logic [Q_W-1:0]     r_y;          // quotient / root being built
  logic [Q_W-1:0]     r_yt;         // root trial value for the current bit
  logic [P_W-1:0]     r_p;          // running power of the trial value
  logic [P_W-1:0]     r_xs;         // x << (n*F_EFF)
  logic [BIT_W-1:0]   r_bit;        // current result bit position
  logic [N_W-1:0]     r_mul_cnt;    // multiplies left for this trial

  logic               r_out_valid;
  logic [OUT_W-1:0]   r_out_data;
  logic               r_out_err;

  logic [N_W:0]       w_div_trial;
  logic [N_W:0]       w_div_diff;
  logic               w_div_ge;
  logic [Q_W-1:0]     w_yt;
  logic [P_W-1:0]     w_prod;
  logic [P_W-1:0]     w_xs;
  logic [OUT_W-1:0]   w_res;
  logic [OUT_W-1:0]   w_out_nx;

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  // NOTE: every signal driven here gets a default first, so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    w_next     = r_state;
    w_in_ready = 1'b0;
    case (r_state)
      S_IDLE, S_DONE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          if (in_data_2 == '0) w_next = S_ERR;
          else if (in_mode)    w_next = S_ROOT_TRY;
          else                 w_next = S_DIV_STEP;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_DIV_STEP: if (r_bit == '0) w_next = S_DONE;
      S_ROOT_TRY: w_next = (r_n == N_W'(1)) ? S_ROOT_CMP : S_ROOT_MUL;
      S_ROOT_MUL: if (r_mul_cnt == N_W'(1)) w_next = S_ROOT_CMP;
      S_ROOT_CMP: w_next = (r_bit == '0) ? S_DONE : S_ROOT_TRY;
      S_ERR:      w_next = S_DONE;
      default:    w_next = S_IDLE;
    endcase
  end

  assign in_ready = w_in_ready;
  assign w_accept = in_valid & w_in_ready;

  // ---------------------------------------------------------------------------
  // Datapath helpers
  // ---------------------------------------------------------------------------
  // Restoring step. Since rem < d, the trial value is below 2d, so the top bit
  // of (trial - d) is a clean borrow flag: clear means trial >= d.
  assign w_div_trial = {r_rem, r_dvd[Q_W-1]};
  assign w_div_diff  = w_div_trial - {1'b0, r_n};
  assign w_div_ge    = ~w_div_diff[N_W];

  assign w_yt   = r_y | ({{(Q_W-1){1'b0}}, 1'b1} << r_bit);
  assign w_prod = r_p * {{(P_W-Q_W){1'b0}}, r_yt};
  assign w_xs   = {{(P_W-IN_W){1'b0}}, in_data_1} << (32'(in_data_2) * F_EFF);

`ifdef DIVROOT_ROUND_EN
  logic [OUT_W:0] w_round;
  assign w_round = {1'b0, r_y[Q_W-1:1]} + {{OUT_W{1'b0}}, r_y[0]};
  assign w_res   = w_round[OUT_W] ? '1 : w_round[OUT_W-1:0];
`else
  assign w_res   = r_y;
`endif

  assign w_out_nx = r_err ? '1 : w_res;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: only the visible outputs are reset. The working registers are always
  // loaded on acceptance before they are read, so resetting them adds nothing.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_err   <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments let the DONE cycle publish the old
      // result while a back-to-back accept reloads r_y and r_err at this edge.
      r_out_valid <= (r_state == S_DONE);
      r_out_data  <= (r_state == S_DONE) ? w_out_nx : '0;
      r_out_err   <= (r_state == S_DONE) & r_err;

      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_accept) begin
            r_n   <= in_data_2;
            r_err <= (in_data_2 == '0);
            r_dvd <= {in_data_1, {F_EFF{1'b0}}};
            r_rem <= '0;
            r_y   <= '0;
            r_bit <= BIT_W'(Q_W - 1);
            r_xs  <= w_xs;
          end
        end
        S_DIV_STEP: begin
          r_rem <= w_div_ge ? w_div_diff[N_W-1:0] : w_div_trial[N_W-1:0];
          r_y   <= {r_y[Q_W-2:0], w_div_ge};
          r_dvd <= r_dvd << 1;
          r_bit <= r_bit - BIT_W'(1);
        end
        S_ROOT_TRY: begin
          r_yt      <= w_yt;
          r_p       <= {{(P_W-Q_W){1'b0}}, w_yt};
          r_mul_cnt <= r_n - N_W'(1);
        end
        S_ROOT_MUL: begin
          r_p       <= w_prod;
          r_mul_cnt <= r_mul_cnt - N_W'(1);
        end
        S_ROOT_CMP: begin
          if (r_p <= r_xs) r_y <= r_yt;
          r_bit <= r_bit - BIT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_div_root_unit_param.sv
// -----------------------------------------------------------------------------
// tb_div_root_unit_param
//
// Self-checking bench for div_root_unit_param. It runs a table of directed
// vectors, a few multi-cycle sequences (back-to-back, busy hold, reset abort),
// and randomized operands. The randomized operands are checked against an
// arithmetic reference model. The same bench covers DIVROOT_ROUND_EN builds.
// -----------------------------------------------------------------------------
module tb_div_root_unit_param;

  localparam int IN_W   = 10;
  localparam int N_W    = 3;
  localparam int FRAC_W = 10;
  localparam int OUT_W  = IN_W + FRAC_W;
`ifdef DIVROOT_ROUND_EN
  localparam int GRD = 1;
`else
  localparam int GRD = 0;
`endif
  localparam int QW = OUT_W + GRD;

`ifdef DIVROOT_ROUND_EN
  localparam logic [OUT_W-1:0] DIV_1000_7 = 20'h23B6E;
`else
  localparam logic [OUT_W-1:0] DIV_1000_7 = 20'h23B6D;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic              in_mode;
  logic [IN_W-1:0]   in_data_1;
  logic [N_W-1:0]    in_data_2;
  logic              out_valid;
  logic [OUT_W-1:0]  out_data;
  logic              out_err;

  int checks = 0;
  int errors = 0;

  div_root_unit_param #(.IN_W(IN_W), .N_W(N_W), .FRAC_W(FRAC_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_data_1 (in_data_1),
    .in_data_2 (in_data_2),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_err   (out_err)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    string            name;
    logic             mode;
    int               x;
    int               n;
    logic [OUT_W-1:0] exp_data;
    logic             exp_err;
    int               exp_lat;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: plain arithmetic on wide integers
  // ---------------------------------------------------------------------------
  function automatic logic [255:0] pw(input longint y, input int n);
    logic [255:0] r;
    r = 256'd1;
    for (int i = 0; i < n; i++) r = r * 256'(y);
    return r;
  endfunction

  // floor(x^(1/n) * 2^f), estimated in floating point and then fixed up exactly.
  function automatic longint root_floor(input int x, input int n, input int f);
    logic [255:0] xs;
    longint y;
    xs = 256'(x) << (n * f);
    y  = longint'($pow(real'(x), 1.0 / real'(n)) * $pow(2.0, real'(f)));
    while (y > 0 && pw(y, n) > xs) y--;
    while (pw(y + 1, n) <= xs) y++;
    return y;
  endfunction

  task automatic model(input logic mode, input int x, input int n,
                       output logic [OUT_W-1:0] d, output logic e, output int lat);
    longint v;
    if (n == 0) begin
      d = '1; e = 1'b1; lat = 2;
    end else begin
      e = 1'b0;
      if (!mode) begin
        v   = (longint'(x) << (FRAC_W + GRD)) / longint'(n);
        lat = QW + 1;
      end else begin
        v   = root_floor(x, n, FRAC_W + GRD);
        lat = QW * (n + 1) + 1;
      end
      if (GRD != 0) v = (v + 1) >>> 1;
      if (v > ((longint'(1) << OUT_W) - 1)) v = (longint'(1) << OUT_W) - 1;
      d = v[OUT_W-1:0];
    end
  endtask

  // ---------------------------------------------------------------------------
  // Drivers. Each task starts and ends 1 time unit after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic wait_result(output logic [OUT_W-1:0] data, output logic err, output int lat);
    lat = -1; data = '0; err = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c; data = out_data; err = out_err;
        break;
      end
    end
    if (lat < 0) check("result_timeout", 64'd0, 64'd1);
  endtask

  task automatic run_op(input logic mode, input int x, input int n,
                        output logic [OUT_W-1:0] data, output logic err, output int lat);
    int guard;
    guard = 0;
    while (!in_ready && guard < 400) begin
      @(posedge clk); #1;
      guard++;
    end
    check("ready_before_op", 64'(in_ready), 64'd1);
    in_valid  = 1'b1;
    in_mode   = mode;
    in_data_1 = x[IN_W-1:0];
    in_data_2 = n[N_W-1:0];
    @(posedge clk); #1;
    in_valid  = 1'b0;
    wait_result(data, err, lat);
  endtask

  vec_t vecs[9];

  initial begin
    logic [OUT_W-1:0] d, md;
    logic             e, me;
    int               lat, mlat, busy, seen;

    vecs[0] = '{"div_1000_7",    1'b0, 1000, 7, DIV_1000_7,  1'b0, QW + 1};
    vecs[1] = '{"root3_1000",    1'b1, 1000, 3, 20'h02800,   1'b0, QW * 4 + 1};
    vecs[2] = '{"root2_2",       1'b1, 2,    2, 20'h005A8,   1'b0, QW * 3 + 1};
    vecs[3] = '{"root1_1023",    1'b1, 1023, 1, 20'hFFC00,   1'b0, QW * 2 + 1};
    vecs[4] = '{"div_0_5",       1'b0, 0,    5, 20'h00000,   1'b0, QW + 1};
    vecs[5] = '{"div_1023_1",    1'b0, 1023, 1, 20'hFFC00,   1'b0, QW + 1};
    vecs[6] = '{"div_by_zero",   1'b0, 5,    0, 20'hFFFFF,   1'b1, 2};
    vecs[7] = '{"root_idx_zero", 1'b1, 7,    0, 20'hFFFFF,   1'b1, 2};
    vecs[8] = '{"root7_0",       1'b1, 0,    7, 20'h00000,   1'b0, QW * 8 + 1};

    rst = 1'b1; in_valid = 1'b0; in_mode = 1'b0; in_data_1 = '0; in_data_2 = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset_in_ready",  64'(in_ready),  64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_out_data",  64'(out_data),  64'd0);
    check("reset_out_err",   64'(out_err),   64'd0);

    // Directed table
    foreach (vecs[i]) begin
      run_op(vecs[i].mode, vecs[i].x, vecs[i].n, d, e, lat);
      check({vecs[i].name, "_data"}, 64'(d),   64'(vecs[i].exp_data));
      check({vecs[i].name, "_err"},  64'(e),   64'(vecs[i].exp_err));
      check({vecs[i].name, "_lat"},  64'(lat), 64'(vecs[i].exp_lat));
      @(posedge clk); #1;
      check({vecs[i].name, "_pulse_end"}, 64'({out_valid, out_data}), 64'd0);
    end

    // Back-to-back: an error op, then a divide accepted in its DONE cycle.
    // in_valid stays high with the second operand while the engine is busy.
    in_valid = 1'b1; in_mode = 1'b1; in_data_1 = 10'd5; in_data_2 = 3'd0;
    @(posedge clk); #1;
    check("b2b_busy_in_ready", 64'(in_ready), 64'd0);
    in_mode = 1'b0; in_data_1 = 10'd1000; in_data_2 = 3'd7;
    @(posedge clk); #1;
    check("b2b_done_in_ready", 64'(in_ready), 64'd1);
    check("b2b_err_not_early", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("b2b_err_valid", 64'(out_valid), 64'd1);
    check("b2b_err_flag",  64'(out_err),   64'd1);
    check("b2b_err_data",  64'(out_data),  64'hFFFFF);
    wait_result(d, e, lat);
    check("b2b_div_data", 64'(d),   64'(DIV_1000_7));
    check("b2b_div_err",  64'(e),   64'd0);
    check("b2b_div_lat",  64'(lat), 64'(QW + 1));

    // Hold in_valid high with scrambled data while busy; only the first
    // operand may be used, and in_ready must stay low until DONE.
    in_valid = 1'b1; in_mode = 1'b0; in_data_1 = 10'd1000; in_data_2 = 3'd7;
    @(posedge clk); #1;
    busy = 0;
    while (!in_ready && busy < 400) begin
      busy++;
      in_mode   = 1'($urandom);
      in_data_1 = IN_W'($urandom);
      in_data_2 = N_W'($urandom);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    check("hold_busy_cycles", 64'(busy), 64'(QW));
    @(posedge clk); #1;
    check("hold_valid", 64'(out_valid), 64'd1);
    check("hold_data",  64'(out_data),  64'(DIV_1000_7));

    // Reset in the middle of a root operation.
    @(posedge clk); #1;
    in_valid = 1'b1; in_mode = 1'b1; in_data_1 = 10'd1000; in_data_2 = 3'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (29) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_in_ready",  64'(in_ready),  64'd1);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_data",  64'(out_data),  64'd0);
    check("abort_out_err",   64'(out_err),   64'd0);
    seen = 0;
    repeat (120) begin
      @(posedge clk); #1;
      if (out_valid) seen = 1;
    end
    check("abort_no_result", 64'(seen), 64'd0);
    run_op(1'b0, 1000, 7, d, e, lat);
    check("after_abort_data", 64'(d),   64'(DIV_1000_7));
    check("after_abort_lat",  64'(lat), 64'(QW + 1));

    // Randomized operands against the reference model
    for (int i = 0; i < 25; i++) begin
      logic rm;
      int   rx, rn;
      rm = 1'($urandom_range(0, 1));
      rx = int'($urandom_range(0, 1023));
      rn = int'($urandom_range(0, 7));
      model(rm, rx, rn, md, me, mlat);
      run_op(rm, rx, rn, d, e, lat);
      if (d !== md || e !== me || lat !== mlat)
        $display("  random op %0d: mode=%0d x=%0d n=%0d", i, rm, rx, rn);
      check("rand_data", 64'(d),   64'(md));
      check("rand_err",  64'(e),   64'(me));
      check("rand_lat",  64'(lat), 64'(mlat));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/div_root_unit_param.md
Name: div_root_unit_param

Overview:
Parametrised fixed-point divide / n-th root engine; successor to the fixed 10-bit div/root block.
- Accepts an unsigned IN_W-bit integer operand plus an N_W-bit divisor or root index.
- Returns an unsigned fixed-point result with IN_W integer and FRAC_W fraction bits.
- Adds a ready/valid input handshake, back-to-back acceptance, and an error flag for a zero second operand.
- Sits between the operand sequencer and the result collector.

Parameters:
IN_W, 10, integer operand width and result integer-bit count
N_W, 3, width of divisor / root index (n in 1..2^N_W-1)
FRAC_W, 10, result fraction bits; OUT_W = IN_W+FRAC_W

Ports:
clk  in  1  clock, rising-edge
rst  in  1  synchronous active-high reset
in_valid  in  1  operand valid; accepted only when in_ready=1
in_ready  out  1  engine can accept an operand this cycle
in_mode  in  1  0=divide, 1=n-th root
in_data_1  in  IN_W  unsigned integer operand x
in_data_2  in  N_W  divisor d or root index n
out_valid  out  1  one-cycle result pulse
out_data  out  OUT_W  result, IN_W.FRAC_W unsigned; 0 when out_valid=0
out_err  out  1  pulses with out_valid when in_data_2==0

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values: in_ready=1, out_valid=0, out_data=0, out_err=0. Internal state returns to IDLE.
- Reset mid-operation aborts the computation; no result is emitted. The first cycle after reset deasserts has in_ready=1.
- States: IDLE, DIV_STEP, ROOT_TRY, ROOT_MUL, ROOT_CMP, ERR, DONE.
- in_ready=1 only in IDLE and DONE. Acceptance in DONE gives back-to-back operation.
- in_valid while in_ready=0 is ignored. Operands and mode are registered on acceptance.
- Accept with in_data_2==0 -> ERR -> DONE: out_err=1, out_data=all ones; latency 2.
- Divide:
  - Computes restoring quotient floor(x*2^FRAC_W/d), one bit per cycle MSB first, OUT_W DIV_STEP cycles, then DONE.
  - Latency L=OUT_W+1: acceptance at edge k gives out_valid high after edge k+L.
- Root:
  - Computes the largest Y (OUT_W bits, MSB first) with Y^n <= x<<(n*FRAC_W).
  - Per bit: ROOT_TRY sets trial bit, P=Yt. ROOT_MUL runs n-1 cycles of P=P*Yt. ROOT_CMP keeps the bit iff P <= scaled x.
  - P is n_max*OUT_W bits wide; no truncation.
  - n=1 yields x<<FRAC_W exactly.
  - Latency L=OUT_W*(n+1)+1.
- DONE lasts one cycle, then IDLE unless a new operand is accepted in DONE.
- Results truncate toward zero. x=0 gives 0 in both modes.

Optional Feature:
DIVROOT_ROUND_EN
- Defined:
  - One extra guard bit is computed: divide +1 cycle, root +(n+1) cycles.
  - Result = truncated + guard (round half up), saturating at all ones.
  - Error path unchanged.
- Undefined: truncation, latencies as above.

Test Plan:
- Divide, x=1000, d=7 -> out_data=0x23B6D (146285), out_err=0, out_valid exactly 21 cycles after acceptance; with DIVROOT_ROUND_EN -> 0x23B6E, latency 22.
- Root, x=1000, n=3 -> 0x02800 (10.0) at latency 81. Root, x=2, n=2 -> 0x005A8 (1448), latency 61.
- Root, x=1023, n=1 -> 0xFFC00 at latency 41. Divide, x=0, d=5 -> 0x00000.
- in_data_2=0 (either mode) -> out_err=1, out_data=0xFFFFF, latency 2. Next operand accepted in the DONE cycle; its result follows correctly.
- in_valid held high with changing data during busy -> only the first operand is used; in_ready low until DONE.
- rst=1 at cycle 30 of a root op -> no out_valid; in_ready=1 and all outputs 0 the cycle after release. New divide 1000/7 then returns 0x23B6D.
